// File: rtl/dlx_fetch_stage.sv
// DLX instruction-fetch stage: owns the PC, reads the instruction SRAM combinationally,
// and fills the IF/ID register with stall, branch-squash and TRAP-halt handling.
module dlx_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter logic [31:0] NOP_INSTR   = 32'h00000000,
  parameter logic [5:0]  TRAP_OPCODE = 6'h11
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] instr_next;
  logic [31:0] pc4_next;
  logic        valid_next;
  logic [31:0] count_next;
  logic        fetch_trap;

  assign imem_addr  = pc;
  assign halted     = (state == HALTED);
  assign pc_plus4   = pc + 32'd4;
  assign fetch_trap = (imem_data[31:26] == TRAP_OPCODE);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = if_id_instr;
    pc4_next   = if_id_pc4;
    valid_next = if_id_valid;
    count_next = fetch_count;

    if (branch_taken) begin
      // Redirect wins over stall and also releases a wrong-path TRAP halt.
      pc_next    = branch_target & 32'hFFFF_FFFC;
      instr_next = NOP_INSTR;
      pc4_next   = '0;
      valid_next = 1'b0;
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (!stall) begin
            instr_next = imem_data;
            pc4_next   = pc_plus4;
            valid_next = 1'b1;
            count_next = fetch_count + 32'd1;
            if (fetch_trap) begin
              state_next = HALTED;
            end else begin
              pc_next = pc_plus4;
            end
          end
        end
        HALTED: begin
          if (!stall) begin
            instr_next = NOP_INSTR;
            pc4_next   = '0;
            valid_next = 1'b0;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      if_id_instr <= instr_next;
      if_id_pc4   <= pc4_next;
      if_id_valid <= valid_next;
      fetch_count <= count_next;
    end
  end

endmodule

// File: tb/tb_dlx_fetch_stage.sv
// Scoreboard bench for dlx_fetch_stage: directed scenarios then random stall/branch/reset traffic,
// checked against an instruction-level reference model.
module tb_dlx_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h00000000;
  localparam logic [31:0] NOP_INSTR = 32'h00000000;
  localparam logic [31:0] TRAP_WORD = 32'h44000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  dlx_fetch_stage #(
    .RESET_PC   (RESET_PC),
    .NOP_INSTR  (NOP_INSTR),
    .TRAP_OPCODE(6'h11)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  // Memory image: pseudo-random non-TRAP words, plus an optional planted TRAP.
  logic        trap_en    = 1'b0;
  logic [31:0] trap_addr  = '0;
  logic        rand_traps = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] x;
    if (trap_en && a == trap_addr) return TRAP_WORD;
    if (rand_traps && ((a >> 2) % 29) == 7) return TRAP_WORD | (a & 32'h0000_FFFF);
    x = (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    if (x[31:26] == 6'h11) x[26] = ~x[26];
    return x;
  endfunction

  // Reference model state
  logic [31:0] m_pc = RESET_PC, m_instr = NOP_INSTR, m_pc4 = '0, m_cnt = '0;
  logic        m_valid = 1'b0, m_halted = 1'b0;

  task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] t);
    logic [31:0] w;
    if (r) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = '0; m_valid = 1'b0;
      m_halted = 1'b0; m_cnt = '0;
    end else if (b) begin
      m_pc = {t[31:2], 2'b00}; m_instr = NOP_INSTR; m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      if (!s) begin m_instr = NOP_INSTR; m_valid = 1'b0; end
    end else if (!s) begin
      w = mem_word(m_pc);
      m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      if (w[31:26] == 6'h11) m_halted = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One cycle of stimulus: drive inputs at negedge, predict the post-edge state.
  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t);
    exp_t e;
    @(negedge clk);
    reset = r; stall = s; branch_taken = b; branch_target = t;
    imem_data = mem_word(imem_addr);
    model_step(r, s, b, t);
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
    e.valid = m_valid; e.halted = m_halted; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_addr", imem_addr, e.pc);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
        chk("if_id_instr", if_id_instr, e.instr);
        if (e.valid) chk("if_id_pc4", if_id_pc4, e.pc4);
        chk("halted", {31'b0, halted}, {31'b0, e.halted});
        chk("fetch_count", fetch_count, e.cnt);
      end
    end
  end

  initial begin
    // Reset
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // Straight-line fetch
    run(54);
    settle();
    chk("straight_addr_D8", imem_addr, 32'h000000D8);
    chk("straight_count_54", fetch_count, 32'd54);
    run(6);

    // Stall at 0x10
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    run(4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("stall_addr", imem_addr, 32'h00000010);
    chk("stall_hold_instr", if_id_instr, mem_word(32'h0000000C));
    run(3);

    // Branch at 0x20 to 0x41, then again with stall held
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    run(8);
    cyc(1'b0, 1'b0, 1'b1, 32'h00000041);
    run(3);
    cyc(1'b0, 1'b1, 1'b1, 32'h00000041);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    run(3);

    // TRAP at 0x18, then release via branch to 0x80
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    trap_en = 1'b1; trap_addr = 32'h00000018;
    run(10);
    settle();
    chk("trap_halted", {31'b0, halted}, 32'd1);
    chk("trap_addr_hold", imem_addr, 32'h00000018);
    cyc(1'b0, 1'b0, 1'b1, 32'h00000080);
    run(5);
    trap_en = 1'b0;

    // PC wrap
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC);
    run(3);

    // Reset while HALTED with fetch_count = 7
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    trap_en = 1'b1; trap_addr = 32'h00000018;
    run(10);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("pre_reset_count_7", fetch_count, 32'd7);
    cyc(1'b1, 1'b1, 1'b1, 32'h12345678);
    settle();
    chk("post_reset_count", fetch_count, 32'd0);
    chk("post_reset_addr", imem_addr, RESET_PC);
    trap_en = 1'b0;

    // Random traffic
    rand_traps = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, b;
      logic [31:0] t;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0: t = 32'hFFFFFFF0 | $urandom_range(0, 15);
        1: t = $urandom_range(0, 255);
        default: t = $urandom;
      endcase
      cyc(r, s, b, t);
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
